// File: rtl/clock_disp_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : clock_disp_pkg
// Brief    : Glyph patterns and digit index constants for the HH.MM.SS display
// Revision : 1.0  initial release
// ============================================================================
package clock_disp_pkg;

    localparam int NUM_DIGITS = 6;

    localparam logic [2:0] DIGIT_SO = 3'd0;
    localparam logic [2:0] DIGIT_ST = 3'd1;
    localparam logic [2:0] DIGIT_MO = 3'd2;
    localparam logic [2:0] DIGIT_MT = 3'd3;
    localparam logic [2:0] DIGIT_HO = 3'd4;
    localparam logic [2:0] DIGIT_HT = 3'd5;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage
`default_nettype wire

// File: rtl/seg7_time_scan_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seg7_time_scan_if
// Brief    : Time word in, scanned display drive out. Optional dim (SEG_DIM_EN).
// Revision : 1.0  initial release
// ============================================================================
interface seg7_time_scan_if;
    import clock_disp_pkg::*;

    logic [23:0]           disp_time;
`ifdef SEG_DIM_EN
    logic                  dim;
`endif
    logic [NUM_DIGITS-1:0] an;
    logic [6:0]            seg;
    logic                  dp;
    logic                  frame_start;

`ifdef SEG_DIM_EN
    modport master (output disp_time, dim, input an, seg, dp, frame_start);
    modport slave  (input disp_time, dim, output an, seg, dp, frame_start);
`else
    modport master (output disp_time, input an, seg, dp, frame_start);
    modport slave  (input disp_time, output an, seg, dp, frame_start);
`endif

endinterface
`default_nettype wire

// File: rtl/bcd_to_seg7.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bcd_to_seg7
// Brief    : Nibble to active-high 7-segment glyph; dash for non-BCD values
// Revision : 1.0  initial release
// ============================================================================
module bcd_to_seg7
    import clock_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_DASH;
        case (nibble)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg7_time_scan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seg7_time_scan
// Brief    : 6-digit multiplexed HH.MM.SS scanner with tear-free frame snapshot.
//            Define SEG_DIM_EN to add a 50% duty dim input.
// Revision : 1.0  initial release
// ============================================================================
module seg7_time_scan
    import clock_disp_pkg::*;
#(
    parameter int DWELL_CYCLES = 2,
    parameter int ACTIVE_LOW   = 1
)(
    input  logic              kh_clk,
    input  logic              reset,
    seg7_time_scan_if.slave   bus
);

    localparam int             DW           = $clog2(DWELL_CYCLES);
    localparam logic [DW-1:0]  C_DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [DW-1:0]  C_DWELL_HALF = DW'(DWELL_CYCLES / 2);
    localparam logic           C_INV        = (ACTIVE_LOW != 0);

    logic [DW-1:0] r_dwell;
    logic [2:0]    r_idx;
    logic [23:0]   r_snap;
    logic          r_primed;

    logic          w_dwell_last;
    logic          w_wrap;
    logic [3:0]    w_nibble;
    logic [6:0]    w_glyph;
    logic [6:0]    w_seg;
    logic          w_dp;
    logic [5:0]    w_an;

    assign w_dwell_last = (r_dwell == C_DWELL_LAST);
    assign w_wrap       = w_dwell_last && (r_idx == DIGIT_HT);

    // The first edge after reset only loads the snapshot; scanning starts on the next one
    always_ff @(posedge kh_clk or negedge reset) begin
        if (!reset) begin
            r_dwell  <= '0;
            r_idx    <= DIGIT_SO;
            r_snap   <= '0;
            r_primed <= 1'b0;
        end else if (!r_primed) begin
            r_primed <= 1'b1;
            r_snap   <= bus.disp_time;
        end else begin
            if (w_dwell_last) begin
                r_dwell <= '0;
                r_idx   <= w_wrap ? DIGIT_SO : r_idx + 3'd1;
            end else begin
                r_dwell <= r_dwell + 1'b1;
            end
            if (w_wrap) begin
                r_snap <= bus.disp_time;
            end
        end
    end

    always_comb begin
        w_nibble = r_snap[23:20];
        case (r_idx)
            DIGIT_SO: w_nibble = r_snap[3:0];
            DIGIT_ST: w_nibble = r_snap[7:4];
            DIGIT_MO: w_nibble = r_snap[11:8];
            DIGIT_MT: w_nibble = r_snap[15:12];
            DIGIT_HO: w_nibble = r_snap[19:16];
            default:  w_nibble = r_snap[23:20];
        endcase
    end

    bcd_to_seg7 u_dec (
        .nibble  (w_nibble),
        .pattern (w_glyph)
    );

    always_comb begin
        w_an  = 6'b000001 << r_idx;
        w_seg = ((r_idx == DIGIT_HT) && (w_nibble == 4'd0)) ? SEG_BLANK : w_glyph;
        // Separator dots blink with the seconds units parity
        w_dp  = ((r_idx == DIGIT_MO) || (r_idx == DIGIT_HO)) && !r_snap[0];
`ifdef SEG_DIM_EN
        if (bus.dim && (r_dwell < C_DWELL_HALF)) begin
            w_seg = SEG_BLANK;
            w_dp  = 1'b0;
        end
`endif
    end

    always_ff @(posedge kh_clk or negedge reset) begin
        if (!reset) begin
            bus.an          <= {6{C_INV}};
            bus.seg         <= {7{C_INV}};
            bus.dp          <= C_INV;
            bus.frame_start <= 1'b0;
        end else if (!r_primed) begin
            bus.an          <= {6{C_INV}};
            bus.seg         <= {7{C_INV}};
            bus.dp          <= C_INV;
            bus.frame_start <= 1'b0;
        end else begin
            bus.an          <= w_an  ^ {6{C_INV}};
            bus.seg         <= w_seg ^ {7{C_INV}};
            bus.dp          <= w_dp  ^ C_INV;
            bus.frame_start <= (r_idx == DIGIT_SO) && (r_dwell == '0);
        end
    end

endmodule
`default_nettype wire
